// File: rtl/timing_gen_mc_if.sv
// timing_gen_mc_if: bundles the control, configuration and status signals of
// timing_gen_mc.
//   master : drives start/stop/mode/period/delay/width, observes status.
//   slave  : the timing generator itself.
// Handshake: start is a level sampled every cycle but acted on only while
// idle. Acceptance is visible as busy rising in the next cycle. Rejection is
// visible as a one-cycle cfg_err. Completion is a one-cycle done pulse.
// stop is a sticky request, honoured only at a frame boundary.
// state_dbg mirrors the FSM state (1 = RUN) for observation.
interface timing_gen_mc_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [CW-1:0]      period;
  logic [NCH*CW-1:0]  delay;
  logic [NCH*CW-1:0]  width;
  logic [NCH-1:0]     ch_out;
  logic               busy;
  logic               done;
  logic               frame_start;
  logic [CW-1:0]      frame_cnt;
  logic               cfg_err;
  logic               state_dbg;

  modport master (
    output start, stop, mode, period, delay, width,
    input  ch_out, busy, done, frame_start, frame_cnt, cfg_err, state_dbg
  );

  modport slave (
    input  start, stop, mode, period, delay, width,
    output ch_out, busy, done, frame_start, frame_cnt, cfg_err, state_dbg
  );
endinterface

// File: rtl/timing_gen_mc.sv
// timing_gen_mc: multi-channel timing generator.
// Produces NCH pulse windows inside a programmable frame. The generator runs
// one frame (one-shot) or repeats frames until a stop request (periodic).
// The configuration is captured into shadow registers when start is accepted.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - timing_gen_mc_if.slave:
//            inputs  start, stop, mode, period, delay, width
//            outputs ch_out, busy, done, frame_start, frame_cnt, cfg_err,
//                    state_dbg
module timing_gen_mc #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  timing_gen_mc_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               mode_s_q, mode_s_d;
  logic [CW-1:0]      period_s_q, period_s_d;
  logic [NCH*CW-1:0]  delay_s_q, delay_s_d;
  logic [NCH*CW-1:0]  width_s_q, width_s_d;
  logic               stop_pending_q, stop_pending_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH-1:0]     ch_out_q, ch_out_d;
  logic               frame_start_q, frame_start_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic               last_cnt;
  logic               stop_seen;
  logic [CW:0]        win_end;

  // FSM and counter next-state.
  always_comb begin
    state_d        = state_q;
    mode_s_d       = mode_s_q;
    period_s_d     = period_s_q;
    delay_s_d      = delay_s_q;
    width_s_d      = width_s_q;
    stop_pending_d = stop_pending_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    cfg_err_d      = 1'b0;

    last_cnt  = (cnt_q == (period_s_q - CW'(1)));
    // A stop arriving in the last cycle of a frame still ends that frame.
    stop_seen = stop_pending_q | bus.stop;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.period != '0) begin
            state_d        = ST_RUN;
            mode_s_d       = bus.mode;
            period_s_d     = bus.period;
            delay_s_d      = bus.delay;
            width_s_d      = bus.width;
            stop_pending_d = 1'b0;
            cnt_d          = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!last_cnt) begin
          cnt_d          = cnt_q + CW'(1);
          stop_pending_d = stop_seen;
        end else if (mode_s_q && !stop_seen) begin
          cnt_d = '0;
        end else begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          stop_pending_d = 1'b0;
          done_d         = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel windows are decoded from the next-cycle count and shadow values,
  // so the registered ch_out lines up with the registered frame_cnt.
  // The window end uses CW+1 bits so delay+width cannot wrap; truncation at
  // the frame end falls out naturally because the count never reaches period.
  always_comb begin
    ch_out_d = '0;
    win_end  = '0;
    for (int i = 0; i < NCH; i++) begin
      win_end = {1'b0, delay_s_d[i*CW +: CW]} + {1'b0, width_s_d[i*CW +: CW]};
      if ((state_d == ST_RUN) &&
          (cnt_d >= delay_s_d[i*CW +: CW]) &&
          ({1'b0, cnt_d} < win_end)) begin
        ch_out_d[i] = 1'b1;
      end
    end
    frame_start_d = (state_d == ST_RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_s_q       <= 1'b0;
      period_s_q     <= '0;
      delay_s_q      <= '0;
      width_s_q      <= '0;
      stop_pending_q <= 1'b0;
      cnt_q          <= '0;
      ch_out_q       <= '0;
      frame_start_q  <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_s_q       <= mode_s_d;
      period_s_q     <= period_s_d;
      delay_s_q      <= delay_s_d;
      width_s_q      <= width_s_d;
      stop_pending_q <= stop_pending_d;
      cnt_q          <= cnt_d;
      ch_out_q       <= ch_out_d;
      frame_start_q  <= frame_start_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign bus.ch_out      = ch_out_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = done_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.state_dbg   = (state_q == ST_RUN);

endmodule

// File: tb/tb_timing_gen_mc.sv
// tb_timing_gen_mc: directed bench for timing_gen_mc (NCH=4, CW=8).
module tb_timing_gen_mc;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  timing_gen_mc_if #(.NCH(NCH), .CW(CW)) bus ();

  timing_gen_mc #(.NCH(NCH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 1'b0;
    bus.period = '0;
    bus.delay  = '0;
    bus.width  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.ch_out !== 4'h0) begin errors++; $display("FAIL reset_ch_out got=%h exp=0", bus.ch_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", bus.frame_start); end
    checks++; if (bus.frame_cnt !== 8'h0) begin errors++; $display("FAIL reset_frame_cnt got=%h exp=0", bus.frame_cnt); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", bus.cfg_err); end
    rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q[$];
    logic [3:0] exp_ch;
    // ch0 0-2, ch1 2-5, ch2 5-9 (truncated), ch3 9
    exp_q = '{4'b0001, 4'b0001, 4'b0011, 4'b0010, 4'b0010,
              4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b1100};
    bus.mode   = 1'b0;
    bus.period = 8'd10;
    bus.delay  = {8'd9, 8'd5, 8'd2, 8'd0};
    bus.width  = {8'd1, 8'd10, 8'd4, 8'd3};
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      exp_ch = exp_q.pop_front();
      checks++;
      if ({bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out} !== {1'b1, (c == 0), 8'(c), exp_ch}) begin
        errors++;
        $display("FAIL one_shot c=%0d got busy=%b fs=%b cnt=%0d ch=%b exp ch=%b",
                 c, bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out, exp_ch);
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done, bus.frame_cnt, bus.ch_out} !== {1'b0, 1'b1, 8'd0, 4'h0}) begin
      errors++;
      $display("FAIL one_shot_done got busy=%b done=%b cnt=%0d ch=%b exp busy=0 done=1 cnt=0 ch=0",
               bus.busy, bus.done, bus.frame_cnt, bus.ch_out);
    end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL one_shot_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_periodic();
    int fs_seen = 0;
    logic [3:0] exp_ch;
    bus.mode   = 1'b1;
    bus.period = 8'd4;
    bus.delay  = 32'h0000_0001;
    bus.width  = 32'h0000_0002;
    bus.start  = 1'b1;
    bus.stop   = 1'b1;            // discarded: start wins in idle
    tick();
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      for (int c = 0; c < 4; c++) begin
        exp_ch = (c == 1 || c == 2) ? 4'b0001 : 4'b0000;
        checks++;
        if ({bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out} !== {1'b1, (c == 0), 8'(c), exp_ch}) begin
          errors++;
          $display("FAIL periodic f=%0d c=%0d got busy=%b fs=%b cnt=%0d ch=%b exp ch=%b",
                   f, c, bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out, exp_ch);
        end
        if (bus.frame_start) fs_seen++;
        if (f == 3 && c == 1) bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
      end
    end
    checks++;
    if ({bus.busy, bus.done, bus.ch_out} !== {1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL periodic_stop got busy=%b done=%b ch=%b exp busy=0 done=1 ch=0", bus.busy, bus.done, bus.ch_out);
    end
    checks++; if (fs_seen != 3) begin errors++; $display("FAIL periodic_frame_count got=%0d exp=3", fs_seen); end
    tick();
  endtask

  task automatic test_cfg_err();
    bus.mode   = 1'b0;
    bus.period = 8'd0;
    bus.delay  = '0;
    bus.width  = '0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    checks++;
    if ({bus.cfg_err, bus.busy, bus.done} !== 3'b100) begin
      errors++;
      $display("FAIL cfg_err_pulse got err=%b busy=%b done=%b exp err=1 busy=0 done=0", bus.cfg_err, bus.busy, bus.done);
    end
    tick();
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width got=%b exp=0", bus.cfg_err); end
    bus.period = 8'd5;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.busy, bus.frame_cnt, bus.ch_out} !== {1'b1, 8'(c), 4'h0}) begin
        errors++;
        $display("FAIL cfg_ok_run c=%0d got busy=%b cnt=%0d ch=%b exp busy=1 ch=0", c, bus.busy, bus.frame_cnt, bus.ch_out);
      end
      tick();
    end
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL cfg_ok_done got busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done); end
    tick();
  endtask

  task automatic test_boundaries();
    int bad = 0;
    bus.mode   = 1'b0;
    bus.period = 8'd255;
    bus.delay  = 32'h0000_00ff;
    bus.width  = 32'h0000_00ff;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 255; c++) begin
      checks++;
      if ({bus.busy, bus.ch_out} !== {1'b1, 4'h0}) begin
        errors++;
        if (bad < 5) $display("FAIL boundary_255 c=%0d got busy=%b ch=%b exp busy=1 ch=0", c, bus.busy, bus.ch_out);
        bad++;
      end
      tick();
    end
    checks++; if ({bus.busy, bus.done, bus.ch_out} !== {1'b0, 1'b1, 4'h0}) begin errors++; $display("FAIL boundary_255_done got busy=%b done=%b ch=%b", bus.busy, bus.done, bus.ch_out); end
    tick();
    // stop in idle does nothing
    bus.stop = 1'b1;
    tick();
    tick();
    bus.stop = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.frame_cnt, bus.ch_out} !== {3'b000, 8'd0, 4'h0}) begin
      errors++;
      $display("FAIL stop_in_idle got busy=%b done=%b err=%b cnt=%0d ch=%b exp all 0",
               bus.busy, bus.done, bus.cfg_err, bus.frame_cnt, bus.ch_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ch;
    bus.mode   = 1'b0;
    bus.period = 8'd8;
    bus.delay  = 32'h0000_0002;
    bus.width  = 32'h0000_0003;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_ch = (c >= 2 && c <= 4) ? 4'b0001 : 4'b0000;
      checks++;
      if ({bus.busy, bus.frame_cnt, bus.ch_out} !== {1'b1, 8'(c), exp_ch}) begin
        errors++;
        $display("FAIL mid_run c=%0d got busy=%b cnt=%0d ch=%b exp ch=%b", c, bus.busy, bus.frame_cnt, bus.ch_out, exp_ch);
      end
      if (c == 3) begin
        bus.period = 8'd3;
        bus.delay  = '0;
        bus.width  = {4{8'hff}};
        bus.start  = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL mid_run_done got busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done); end
    bus.start = 1'b1;           // start during the done cycle
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out} !== {1'b1, (c == 0), 8'(c), 4'hf}) begin
        errors++;
        $display("FAIL back_to_back c=%0d got busy=%b fs=%b cnt=%0d ch=%b exp ch=f", c, bus.busy, bus.frame_start, bus.frame_cnt, bus.ch_out);
      end
      tick();
    end
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL back_to_back_done got busy=%b done=%b", bus.busy, bus.done); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp_ch;
    bus.mode   = 1'b1;
    bus.period = 8'd8;
    bus.delay  = '0;
    bus.width  = {4{8'd8}};
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if ({bus.busy, bus.frame_cnt, bus.ch_out} !== {1'b1, 8'd5, 4'hf}) begin
      errors++;
      $display("FAIL pre_reset got busy=%b cnt=%0d ch=%b exp busy=1 cnt=5 ch=f", bus.busy, bus.frame_cnt, bus.ch_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.frame_start, bus.frame_cnt, bus.ch_out} !== {3'b000, 8'd0, 4'h0}) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b fs=%b cnt=%0d ch=%b exp all 0",
               bus.busy, bus.done, bus.frame_start, bus.frame_cnt, bus.ch_out);
    end
    tick();
    #2 rst = 1'b0;
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL reset_no_done got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    bus.mode   = 1'b0;
    bus.period = 8'd3;
    bus.delay  = 32'h0000_0001;
    bus.width  = 32'h0000_0001;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_ch = (c == 1) ? 4'b0001 : 4'b0000;
      checks++;
      if ({bus.busy, bus.frame_cnt, bus.ch_out} !== {1'b1, 8'(c), exp_ch}) begin
        errors++;
        $display("FAIL post_reset_run c=%0d got busy=%b cnt=%0d ch=%b exp ch=%b", c, bus.busy, bus.frame_cnt, bus.ch_out, exp_ch);
      end
      tick();
    end
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL post_reset_done got busy=%b done=%b", bus.busy, bus.done); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_idle_inputs();
    #12;
    test_reset();
    test_one_shot();
    test_periodic();
    test_cfg_err();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
